// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and mux selects, and guards variable-latency memory with a timeout.
module multicycle_control #(
    parameter bit MEM_WAIT = 1'b1,
    parameter int TO_W     = 4,
    parameter int TO_MAX   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        RST     = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADDR = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        RWB     = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        JAL     = 4'd11,
        IEXEC   = 4'd12,
        IWB     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001010;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0] CNT_FULL = '1;

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] count;
    logic [TO_W-1:0] count_next;
    logic            wait_state;
    logic            mem_done;
    logic            timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Memory completes on mem_ready, or every cycle when waits are disabled;
    // a ready in the limit cycle wins over the timeout.
    always_comb begin
        wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        mem_done   = !MEM_WAIT || mem_ready;
        timeout    = MEM_WAIT && wait_state && !mem_ready && (count == TO_LIMIT);
        count_next = '0;
        if (MEM_WAIT && wait_state && !mem_ready && !timeout)
            count_next = (count == CNT_FULL) ? count : count + 1'b1;
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        bus_err       = timeout;

        case (state)
            RST: state_next = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (timeout) begin
                    state_next = FETCH;
                end else if (mem_done) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:        state_next = EXEC;
                    OP_LW, OP_SW:    state_next = MEMADDR;
                    OP_BEQ:          state_next = BRANCH;
                    OP_J:            state_next = JUMP;
                    OP_JAL:          state_next = JAL;
                    OP_ADDI, OP_SUBI: state_next = IEXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (timeout)
                    state_next = FETCH;
                else if (mem_done)
                    state_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_next = FETCH;
            end
            MEMWR: begin
                ior_d     = 1'b1;
                mem_write = !timeout;
                if (timeout || mem_done)
                    state_next = FETCH;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                state_next = FETCH;
            end
            IEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (opcode == OP_SUBI) ? 2'b01 : 2'b00;
                state_next = IWB;
            end
            IWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = FETCH;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                state_next = FETCH;
            end
            default: state_next = RST;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds the expected per-cycle step list of each instruction
// from its opcode and memory wait counts, then checks state and every output cycle by cycle.
module tb_multicycle_control;

    localparam int TO_MAX = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       illegal_op, bus_err;
    logic [3:0] state_o;
    logic [19:0] outs;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       berr;
    } step_t;

    step_t plan[$];

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT(1'b1), .TO_W(4), .TO_MAX(TO_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ior_d(ior_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .bus_err(bus_err),
        .state_o(state_o)
    );

    assign outs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, reg_write,
                   alu_src_a, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source,
                   illegal_op, bus_err};

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SUBI};
    endfunction

    // Expected outputs of one step, straight from the per-state output table.
    function automatic logic [19:0] exp_out(input step_t s, input logic [5:0] op);
        logic pcw, pwc, iord, mr, mw, irw, rw, asa, ill;
        logic [1:0] rdst, m2r, asb, aop, psrc;
        {pcw, pwc, iord, mr, mw, irw, rw, asa, ill} = '0;
        {rdst, m2r, asb, aop, psrc} = '0;
        case (s.st)
            4'd1:  begin mr = 1; asb = 2'b01; irw = s.rdy && !s.berr; pcw = s.rdy && !s.berr; end
            4'd2:  begin asb = 2'b11; ill = !is_legal(op); end
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 2'b01; end
            4'd6:  begin iord = 1; mw = !s.berr; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 2'b01; end
            4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd10: begin pcw = 1; psrc = 2'b10; end
            4'd11: begin pcw = 1; psrc = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
            4'd12: begin asa = 1; asb = 2'b10; aop = (op == OP_SUBI) ? 2'b01 : 2'b00; end
            4'd13: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pwc, iord, mr, mw, irw, rw, asa, rdst, m2r, asb, aop, psrc, ill, s.berr};
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] exp_st, input logic [19:0] exp_o);
        checks++;
        assert (state_o === exp_st) passes++;
        else $error("[TB] FAIL %s state: observed %0d expected %0d", tag, state_o, exp_st);
        checks++;
        assert (outs === exp_o) passes++;
        else $error("[TB] FAIL %s outputs: observed %b expected %b", tag, outs, exp_o);
    endtask

    // A memory step of w wait cycles: w idle cycles then completion, or abort on timeout.
    task automatic add_mem(input logic [3:0] st, input int w, output bit aborted);
        aborted = 0;
        if (w > TO_MAX) begin
            for (int i = 0; i < TO_MAX; i++) plan.push_back('{st, 1'b0, 1'b0});
            plan.push_back('{st, 1'b0, 1'b1});
            aborted = 1;
        end else begin
            for (int i = 0; i < w; i++) plan.push_back('{st, 1'b0, 1'b0});
            plan.push_back('{st, 1'b1, 1'b0});
        end
    endtask

    task automatic add_step(input logic [3:0] st);
        plan.push_back('{st, 1'($urandom), 1'b0});
    endtask

    task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
        bit ab;
        plan.delete();
        add_mem(4'd1, fw, ab);
        if (ab) return;
        add_step(4'd2);
        case (op)
            OP_LW:   begin add_step(4'd3); add_mem(4'd4, mw, ab); if (!ab) add_step(4'd5); end
            OP_SW:   begin add_step(4'd3); add_mem(4'd6, mw, ab); end
            OP_R:    begin add_step(4'd7); add_step(4'd8); end
            OP_BEQ:  add_step(4'd9);
            OP_J:    add_step(4'd10);
            OP_JAL:  add_step(4'd11);
            OP_ADDI, OP_SUBI: begin add_step(4'd12); add_step(4'd13); end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async", 4'd0, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("reset_release", 4'd0, 20'd0);
    endtask

    // Runs one instruction; stop_at >= 0 asserts reset in the middle of that step.
    task automatic applyStimulus(input logic [5:0] op, input int fw, input int mw, input int stop_at);
        build_plan(op, fw, mw);
        foreach (plan[i]) begin
            @(negedge clk);
            opcode    = (plan[i].st == 4'd1) ? 6'($urandom) : op;
            mem_ready = plan[i].rdy;
            #1 checkOutput($sformatf("op%b fw%0d mw%0d step%0d", op, fw, mw, i),
                           plan[i].st, exp_out(plan[i], op));
            if (i == stop_at) begin
                do_reset();
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops [9];
        int fw, mw;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SUBI, OP_BAD};

        #2 checkOutput("power_on_reset", 4'd0, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("first_release", 4'd0, 20'd0);

        foreach (ops[k]) applyStimulus(ops[k], 0, 0, -1);
        applyStimulus(6'b000001, 0, 0, -1);
        applyStimulus(OP_LW, 3, 2, -1);
        applyStimulus(OP_SW, 0, 20, -1);
        applyStimulus(OP_SW, 0, TO_MAX, -1);
        applyStimulus(OP_LW, 0, TO_MAX + 1, -1);
        applyStimulus(OP_LW, TO_MAX + 1, 0, -1);
        applyStimulus(OP_R, TO_MAX, 0, -1);
        applyStimulus(OP_LW, 0, 3, 4);
        applyStimulus(OP_JAL, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            applyStimulus(ops[$urandom_range(0, 8)], fw, mw, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
